tis_system_nios2_qsys_0_oci_trace_capture: RTL

- Parametrised successor to the OCI test-bench trace sink: captures DCT trace words (dct_buffer + dct_count tag) into a circular buffer instead of discarding them.
- Reacts to test_ending (post-trigger window) and test_has_ended (immediate freeze), then drains captured entries oldest-first over a simple read handshake.
- Sits beside the Nios II OCI debug logic and feeds the debug/host readout path.

---
 rtl/tis_oci_trace_pkg.sv | 11 +
 rtl/tis_system_nios2_qsys_0_oci_trace_ram.sv | 20 ++
 rtl/tis_system_nios2_qsys_0_oci_trace_capture.sv | 119 +++++++++++
 3 files changed

// File: rtl/tis_oci_trace_pkg.sv
// Shared definitions for the OCI trace capture block: state encoding and entry width.
package tis_oci_trace_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_POST    = 2'd2;
  localparam logic [1:0] ST_FROZEN  = 2'd3;

  function automatic int entry_w(input int trace_w, input int count_w);
    return trace_w + count_w;
  endfunction
endpackage

// File: rtl/tis_system_nios2_qsys_0_oci_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port, no reset.
module tis_system_nios2_qsys_0_oci_trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 34
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/tis_system_nios2_qsys_0_oci_trace_capture.sv
// Circular DCT trace capture with trigger/post-trigger window and oldest-first drain.
module tis_system_nios2_qsys_0_oci_trace_capture
  import tis_oci_trace_pkg::*;
#(
  parameter int TRACE_W   = 30,
  parameter int COUNT_W   = 4,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         arm,
  input  logic                         wrap_mode,
  input  logic                         dct_valid,
  input  logic [TRACE_W-1:0]           dct_buffer,
  input  logic [COUNT_W-1:0]           dct_count,
  input  logic                         test_ending,
  input  logic                         test_has_ended,
  input  logic                         rd_req,
  output logic                         rd_valid,
  output logic [TRACE_W+COUNT_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]       fill_level,
  output logic                         overflow,
  output logic [1:0]                   state_o,
  output logic                         frozen
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int PW = $clog2(DEPTH + 1);
  localparam int EW = entry_w(TRACE_W, COUNT_W);

  logic [1:0]    state;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] fill;
  logic [PW-1:0] post_cnt;
  logic          wrap_q, ovf, rd_valid_q;
  logic [EW-1:0] ram_q;
  logic          wr_try, full, wr_en, rd_fire, armed;

  assign armed   = arm && (state == ST_IDLE || state == ST_FROZEN);
  assign wr_try  = dct_valid && (state == ST_CAPTURE || state == ST_POST);
  assign full    = (fill == FW'(DEPTH));
  assign wr_en   = wr_try && (!full || wrap_q);
  // arm restarts capture, so a read in the same cycle is discarded
  assign rd_fire = (state == ST_FROZEN) && rd_req && !arm && (fill != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      post_cnt   <= '0;
      wrap_q     <= 1'b0;
      ovf        <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (armed) begin
        state  <= ST_CAPTURE;
        wr_ptr <= '0;
        rd_ptr <= '0;
        fill   <= '0;
        ovf    <= 1'b0;
        wrap_q <= wrap_mode;
      end else begin
        // full + wrapping: overwrite oldest, so the read pointer follows
        if (wr_en) begin
          wr_ptr <= wr_ptr + AW'(1);
          if (full) rd_ptr <= rd_ptr + AW'(1);
          else      fill   <= fill + FW'(1);
        end
        if (wr_try && full) ovf <= 1'b1;
        if (rd_fire) begin
          rd_ptr <= rd_ptr + AW'(1);
          fill   <= fill - FW'(1);
        end
        case (state)
          ST_CAPTURE: begin
            if (test_has_ended) state <= ST_FROZEN;
            else if (test_ending) begin
              if (POST_TRIG == 0) state <= ST_FROZEN;
              else begin
                state    <= ST_POST;
                post_cnt <= PW'(POST_TRIG);
              end
            end
          end
          ST_POST: begin
            if (test_has_ended) state <= ST_FROZEN;
            else if (wr_try) begin
              post_cnt <= post_cnt - PW'(1);
              if (post_cnt == PW'(1)) state <= ST_FROZEN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  tis_system_nios2_qsys_0_oci_trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({dct_count, dct_buffer}),
    .re    (rd_fire),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // RAM output is unreset; mask it so rd_data reads zero outside a valid pulse
  assign rd_data    = rd_valid_q ? ram_q : '0;
  assign rd_valid   = rd_valid_q;
  assign fill_level = fill;
  assign overflow   = ovf;
  assign state_o    = state;
  assign frozen     = (state == ST_FROZEN);
endmodule
